// File: rtl/dram_arbiter.sv
// Round-robin arbiter that shares one data DRAM between NUM_CORES cores.
// One RAM transaction is sequenced at a time: IDLE -> ISSUE -> (WAIT) -> ACK.
// Also gathers the per-core End flags into a single sticky all_end.
module dram_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we_in,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_in,
  input  logic [NUM_CORES*DATA_W-1:0] wdata_in,
  input  logic [NUM_CORES-1:0]        core_end,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic                        ram_we,
  output logic [DATA_W-1:0]           ram_din,
  input  logic [DATA_W-1:0]           ram_dout,
  output logic                        all_end
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("dram_arbiter: RD_LAT must be in 1..4");
  end
  if (NUM_CORES < 2 || NUM_CORES > 8) begin : g_bad_num_cores
    $error("dram_arbiter: NUM_CORES must be in 2..8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_d;

  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    idx_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          cnt;
  logic                lat_done;
  logic [NUM_CORES-1:0] end_flags;

  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found;
  logic [IDX_W-1:0]    cand;

  assign lat_done = (cnt == 3'(RD_LAT - 1));
  assign all_end  = &end_flags;

  // Round-robin pick: first requester searching upward from last_grant+1 with wrap.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_CORES);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and RAM/grant outputs; everything returns to zero in IDLE.
  always_comb begin
    state_d  = state;
    gnt      = '0;
    ack      = '0;
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    case (state)
      IDLE: begin
        if (sel_found) state_d = ISSUE;
      end
      ISSUE: begin
        gnt[idx_q] = 1'b1;
        ram_addr   = addr_q;
        ram_din    = wdata_q;
        ram_we     = we_q;
        state_d    = we_q ? ACK : WAIT;
      end
      WAIT: begin
        gnt[idx_q] = 1'b1;
        ram_addr   = addr_q;
        ram_din    = wdata_q;
        if (lat_done) state_d = ACK;
      end
      ACK: begin
        gnt[idx_q] = 1'b1;
        ack[idx_q] = 1'b1;
        ram_addr   = addr_q;
        ram_din    = wdata_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction latch, read-latency counter, read data capture and grant history.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      rdata      <= '0;
      last_grant <= IDX_W'(NUM_CORES - 1);
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            idx_q   <= sel_idx;
            we_q    <= we_in[sel_idx];
            addr_q  <= addr_in[sel_idx*ADDR_W +: ADDR_W];
            wdata_q <= wdata_in[sel_idx*DATA_W +: DATA_W];
          end
        end
        ISSUE: begin
          cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + 3'd1;
          if (lat_done) rdata <= ram_dout;
        end
        ACK: begin
          last_grant <= idx_q;
        end
        default: ;
      endcase
    end
  end

  // Sticky per-core End flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      end_flags <= '0;
    end else begin
      end_flags <= end_flags | core_end;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: a transaction-level model predicts grant
// order, RAM write pulses, ack timing and read data; a negedge monitor compares.
module tb_dram_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req, we_in, core_end;
  logic [N*AW-1:0]   addr_in;
  logic [N*DW-1:0]   wdata_in;
  logic [N-1:0]      gnt, ack;
  logic [DW-1:0]     rdata, ram_din, ram_dout;
  logic [AW-1:0]     ram_addr;
  logic              ram_we, all_end;

  dram_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req(req), .we_in(we_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .core_end(core_end), .gnt(gnt), .ack(ack),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .all_end(all_end)
  );

  // Environment DRAM with RL cycles of read latency.
  bit [DW-1:0] mem  [0:(1<<AW)-1];
  bit [DW-1:0] pipe [0:RL-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    pipe[0] <= mem[ram_addr];
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_dout = pipe[RL-1];

  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int cyc; int core; bit rd; logic [DW-1:0] data; } ack_t;
  wr_t  wr_q[$];
  ack_t ack_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 1'b0;

  // Reference model state.
  bit [DW-1:0]   ref_mem [0:(1<<AW)-1];
  logic [N-1:0]  pend, drop, cont_mask, flags;
  logic          p_we [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wdata [N];
  int            mode;
  bit            busy, cur_we, rst_was;
  int            cur_core, cur_issue, cur_ack, last_g;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_old;
  logic [N-1:0]  exp_gnt;
  logic [AW-1:0] exp_addr;
  bit            exp_all_end;
  logic [DW-1:0] hold;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int c);
    logic [N-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic new_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i]    = 1'b1;
    drop[i]    = 1'b0;
    p_we[i]    = w;
    p_addr[i]  = a;
    p_wdata[i] = d;
  endtask

  // Advance one cycle: apply reset effects, retire, refill, drive, arbitrate.
  task automatic step(input bit r, input logic [N-1:0] ce);
    int c;
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_was) begin
      if (busy && cur_we && cur_issue >= cyc) ref_mem[cur_addr] = cur_old;
      while (wr_q.size() != 0 && wr_q[$].cyc >= cyc) void'(wr_q.pop_back());
      while (ack_q.size() != 0 && ack_q[$].cyc >= cyc) void'(ack_q.pop_back());
      busy = 1'b0; pend = '0; drop = '0; last_g = N - 1; flags = '0;
    end
    if (busy && cyc > cur_ack) begin
      pend[cur_core] = 1'b0;
      drop[cur_core] = 1'b0;
      busy = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        if (mode == 1 && $urandom_range(0, 99) < 35)
          new_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom());
        else if (mode == 2 && cont_mask[i])
          new_req(i, 1'b1, AW'(32'h20 + i), $urandom());
      end
    end
    if (mode == 1 && busy && cyc >= cur_issue && $urandom_range(0, 3) == 0) drop[cur_core] = 1'b1;
    rst = r;
    core_end = ce;
    for (int i = 0; i < N; i++) begin
      req[i] = pend[i] & ~drop[i];
      we_in[i] = p_we[i];
      addr_in[i*AW +: AW] = p_addr[i];
      wdata_in[i*DW +: DW] = p_wdata[i];
    end
    exp_all_end = &flags;
    flags = flags | ce;
    if (!busy && !r && req != '0) begin
      c = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (last_g + k) % N;
        if (c < 0 && req[idx]) c = idx;
      end
      busy = 1'b1; cur_core = c; cur_we = p_we[c]; cur_addr = p_addr[c];
      cur_issue = cyc + 1;
      cur_ack = cur_we ? cyc + 2 : cyc + 2 + RL;
      last_g = c;
      if (cur_we) begin
        cur_old = ref_mem[cur_addr];
        ref_mem[cur_addr] = p_wdata[c];
        wr_q.push_back('{cyc + 1, cur_addr, p_wdata[c]});
        ack_q.push_back('{cur_ack, c, 1'b0, '0});
      end else begin
        ack_q.push_back('{cur_ack, c, 1'b1, ref_mem[cur_addr]});
      end
    end
    exp_gnt = '0;
    exp_addr = '0;
    if (busy && cyc >= cur_issue && cyc <= cur_ack) begin
      exp_gnt[cur_core] = 1'b1;
      exp_addr = cur_addr;
    end
    rst_was = r;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || pend != '0) && n < budget) begin
      step(1'b0, '0);
      n++;
    end
    if (n == budget) begin
      failures++;
      $display("FAIL drain_timeout: model still busy after %0d cycles", budget);
    end
  endtask

  // Monitor: compares DUT outputs against the model's expectations.
  always @(negedge clk) begin
    wr_t  w;
    ack_t a;
    if (started) begin
      check("gnt", 64'(gnt), 64'(exp_gnt));
      check("ram_addr", 64'(ram_addr), 64'(exp_addr));
      check("all_end", 64'(all_end), 64'(exp_all_end));
      if (ram_we) begin
        if (wr_q.size() == 0) check("ram_we_unexpected", 64'(ram_we), 64'd0);
        else begin
          w = wr_q.pop_front();
          check("wr_cycle", 64'(cyc), 64'(w.cyc));
          check("wr_addr", 64'(ram_addr), 64'(w.addr));
          check("wr_data", 64'(ram_din), 64'(w.data));
        end
      end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
        w = wr_q.pop_front();
        check("ram_we_missing", 64'(ram_we), 64'd1);
      end
      if (ack != '0) begin
        if (ack_q.size() == 0) check("ack_unexpected", 64'(ack), 64'd0);
        else begin
          a = ack_q.pop_front();
          check("ack_core", 64'(ack), 64'(onehot(a.core)));
          check("ack_cycle", 64'(cyc), 64'(a.cyc));
          if (a.rd) begin
            check("rdata_at_ack", 64'(rdata), 64'(a.data));
            hold = a.data;
          end else begin
            check("rdata_hold_wr", 64'(rdata), 64'(hold));
          end
        end
      end else begin
        if (ack_q.size() != 0 && ack_q[0].cyc <= cyc) begin
          a = ack_q.pop_front();
          check("ack_missing", 64'(ack), 64'(onehot(a.core)));
        end
        check("rdata_hold", 64'(rdata), 64'(hold));
      end
      if (rst) hold = '0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ce;
    rst = 1'b1; req = '0; we_in = '0; addr_in = '0; wdata_in = '0; core_end = '0;
    mode = 0; cont_mask = '0; busy = 1'b0; pend = '0; drop = '0; flags = '0;
    last_g = N - 1; rst_was = 1'b1; hold = '0; exp_gnt = '0; exp_addr = '0; exp_all_end = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
    end

    step(1'b1, '0);
    step(1'b1, '0);
    started = 1'b1;
    step(1'b0, '0);

    // Single write from core 2, then read it back from core 1.
    new_req(2, 1'b1, 12'h005, 32'hDEADBEEF);
    wait_idle(50);
    new_req(1, 1'b0, 12'h005, '0);
    wait_idle(50);

    // All cores write at once after reset: order 0,1,2,3.
    step(1'b1, '0);
    step(1'b0, '0);
    for (int i = 0; i < N; i++) new_req(i, 1'b1, AW'(32'h10 + i), 32'hC0DE_0000 + 32'(i));
    wait_idle(100);

    // Cores 0 and 2 request continuously.
    mode = 2; cont_mask = 4'b0101;
    repeat (40) step(1'b0, '0);
    mode = 0;
    wait_idle(100);

    // Core 3 read aborted by reset in WAIT; afterwards everybody requests.
    new_req(3, 1'b0, 12'h012, '0);
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b1, '0);
    step(1'b0, '0);
    for (int i = 0; i < N; i++) new_req(i, 1'b0, AW'(32'h10 + i), '0);
    wait_idle(100);

    // End-flag aggregation.
    step(1'b1, '0);
    step(1'b0, '0);
    for (int k = 0; k < 25; k++) begin
      ce = '0;
      if (k == 10) ce = 4'b0001;
      if (k == 12) ce = 4'b0100;
      if (k == 15) ce = 4'b0010;
      if (k == 20) ce = 4'b1000;
      step(1'b0, ce);
    end

    // Randomized traffic, including req dropped after latch.
    mode = 1;
    repeat (1500) step(1'b0, '0);
    mode = 0;
    wait_idle(200);

    step(1'b1, '0);
    repeat (3) step(1'b0, '0);

    check("scoreboard_empty", 64'(ack_q.size() + wr_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
Shares the single data DRAM between NUM_CORES processor cores. Each core's memory port (address, write enable, write data) is arbitrated round-robin, and the arbiter sequences one RAM transaction at a time. A per-core acknowledge returns read data. The block also aggregates the cores' End flags into one all_end completion signal for the top level.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
ADDR_W, 12, DRAM address width (matches core AR_out)
DATA_W, 32, DRAM data width (matches core DR_out/Data)
RD_LAT, 1, DRAM read latency in cycles from address to valid ram_dout (1..4; out of range is an elaboration error)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
req  input  NUM_CORES  per-core access request
we_in  input  NUM_CORES  per-core write enable (1=write, 0=read)
addr_in  input  NUM_CORES*ADDR_W  packed per-core addresses, core i at [i*ADDR_W +: ADDR_W]
wdata_in  input  NUM_CORES*DATA_W  packed per-core write data
core_end  input  NUM_CORES  per-core End flag (level or pulse)
gnt  output  NUM_CORES  one-hot grant, high for the whole transaction
ack  output  NUM_CORES  one-cycle completion pulse to the granted core
rdata  output  DATA_W  read data, valid while ack is high
ram_addr  output  ADDR_W  DRAM address
ram_we  output  1  DRAM write enable
ram_din  output  DATA_W  DRAM write data
ram_dout  input  DATA_W  DRAM read data
all_end  output  1  high once every core has signalled End

Behaviour:
- Reset values: state IDLE, gnt=0, ack=0, rdata=0, ram_addr=0, ram_we=0, ram_din=0, all_end=0, end flags=0. last_grant=NUM_CORES-1, so core 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - req is sampled only in this state.
  - If any req bit is set, select the first requester searching from (last_grant+1) mod NUM_CORES upward with wrap.
  - Latch the selected index, its we, addr and wdata, then go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE:
  - gnt[idx]=1; ram_addr and ram_din take the latched values.
  - ram_we = latched we, for this cycle only.
  - Write: go to ACK. Read: go to WAIT with the wait counter at 0.
- WAIT:
  - The counter increments each cycle.
  - When counter==RD_LAT-1, register rdata<=ram_dout and go to ACK.
- ACK:
  - ack[idx]=1 for exactly one cycle; last_grant<=idx; go to IDLE.
  - rdata holds its value until the next read capture. For writes rdata is unchanged.
- Output hold rules:
  - gnt[idx] is high from ISSUE through ACK and is 0 in IDLE.
  - ram_addr holds the latched address from ISSUE through ACK and returns to 0 in IDLE.
  - ram_we is never high outside ISSUE.
- Latency, with the request seen in IDLE at cycle t:
  - Write: ram_we at t+1, ack at t+2.
  - Read: address at t+1, capture at t+1+RD_LAT, ack at t+2+RD_LAT.
- Requester rule: hold req, we, addr and wdata stable until ack.
  - Dropping req after the latch does not abort the transaction; it still completes and acks.
  - A core needing back-to-back accesses keeps req high; it is re-arbitrated in the IDLE cycle after ACK.
- Fairness: with all cores requesting continuously, grants rotate 0,1,...,N-1,0. No core waits more than N-1 transactions.
- all_end:
  - Per-core sticky flag, set on any cycle where core_end[i]=1.
  - all_end=1 on the cycle after the last flag is set. Flags and all_end are cleared only by rst.
  - Arbitration continues regardless of all_end.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. The next cycle shows reset values (ram_we=0, gnt=0). A pending write that had not reached ISSUE is never written.
- Simultaneous events: req bits arriving during ISSUE/WAIT/ACK wait for IDLE. If rst and req are both high in the same cycle, rst wins.

Test Plan:
1. Write: after reset, core 2 requests we=1, addr=0x005, wdata=0xDEADBEEF at t -> ram_we=1 only at t+1 with ram_addr=0x005, ram_din=0xDEADBEEF; gnt=4'b0100 at t+1..t+2; ack[2] at t+2 only.
2. Read (RD_LAT=1, RAM model holding 0xDEADBEEF at 0x005): core 1 reads 0x005 at t -> ram_we stays 0; ack[1] at t+3 with rdata=0xDEADBEEF. Repeat with RD_LAT=3 -> ack at t+5.
3. After reset, all four cores request writes to addresses 0x010..0x013 simultaneously -> ram_we pulses carry addresses 0x010,0x011,0x012,0x013 in order; ack order 0,1,2,3; gnt always one-hot or zero.
4. Cores 0 and 2 request continuously -> grant sequence 0,2,0,2; neither core gets two consecutive grants.
5. Core 3 read in progress: assert rst for one cycle during WAIT -> no ack[3]; next cycle gnt=0, ram_we=0, rdata=0. The next request with all cores requesting goes to core 0.
6. Pulse core_end[0] at cycle 10, core_end[2] at 12, core_end[1] at 15 -> all_end stays 0. Pulse core_end[3] at 20 -> all_end=1 from cycle 21 onward, held until rst.
